leb128_decoder: RTL and testbench

Streaming LEB128 immediate decoder in the core's decode stage. It sits directly downstream of the byte fetch from program ROM and upstream of the operand stack. It consumes one instruction-stream byte per cycle and produces a 64-bit operand for i32/i64 constants, local indices and branch depths. Malformed encodings are flagged so the core can raise a trap.

---
 rtl/leb128_decoder.sv | 95 +++++++++
 tb/tb_leb128_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/leb128_decoder.sv
// leb128_decoder: streaming one-byte-per-cycle LEB128 immediate decoder with malformed-encoding detection
module leb128_decoder #(
    parameter int OUT_W = 64,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_64,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_value,
    output logic [LEN_W-1:0] out_len,
    input  logic             out_ready,
    output logic             error
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERR} state_t;
    state_t             state;
    logic               sgn;
    logic               w64;
    logic [OUT_W-1:0]   acc;
    logic [LEN_W-1:0]   count;
    logic               launch;
    logic               accept;
    logic               last;
    logic               term;
    logic               bad;
    logic [6:0]         shift;
    logic [6:0]         nbits;
    logic [OUT_W-1:0]   acc_next;
    logic [OUT_W-1:0]   sval;
    logic [OUT_W-1:0]   fin;
    // Byte accumulation, terminating-byte validation and final sign/zero extension
    always_comb begin
        launch   = start && (state == IDLE || state == ERR || (state == DONE && out_ready));
        accept   = state == ACCUM && in_valid && in_ready;
        last     = count == (w64 ? LEN_W'(9) : LEN_W'(4));
        term     = !in_byte[7] || last;
        shift    = 7'(count) * 7'd7;
        nbits    = shift + 7'd7;
        acc_next = acc | ({{(OUT_W-7){1'b0}}, in_byte[6:0]} << shift);
        bad      = in_byte[7] ? last :
                   !last ? 1'b0 :
                   w64 ? (sgn ? !(in_byte[6:0] == 7'h00 || in_byte[6:0] == 7'h7f) : |in_byte[6:1]) :
                   (sgn ? in_byte[6:4] != {3{in_byte[3]}} : |in_byte[6:4]);
        sval     = acc_next | ((sgn && in_byte[6]) ? ({OUT_W{1'b1}} << nbits) : '0);
        fin      = w64 ? sval :
                   sgn ? {{(OUT_W-32){sval[31]}}, sval[31:0]} : {{(OUT_W-32){1'b0}}, sval[31:0]};
    end
    // Control FSM with registered handshakes, result and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sgn       <= 1'b0;
            w64       <= 1'b0;
            acc       <= '0;
            count     <= '0;
            out_value <= '0;
            out_len   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            error     <= 1'b0;
        end else if (launch) begin
            state     <= ACCUM;
            sgn       <= is_signed;
            w64       <= is_64;
            acc       <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            error     <= 1'b0;
        end else if (accept) begin
            acc   <= acc_next;
            count <= count + LEN_W'(1);
            if (term) begin
                in_ready <= 1'b0;
                if (bad) begin
                    state <= ERR;
                    error <= 1'b1;
                end else begin
                    state     <= DONE;
                    out_value <= fin;
                    out_len   <= count + LEN_W'(1);
                    out_valid <= 1'b1;
                end
            end
        end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_leb128_decoder.sv
// tb_leb128_decoder: scoreboard bench for the LEB128 decoder
module tb_leb128_decoder;
    typedef struct {
        logic        err;
        logic [63:0] v;
        logic [3:0]  len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        is_64 = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic        out_ready = 1'b1;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [7:0]  bq[$];
    logic        err_d = 1'b0;

    leb128_decoder dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .is_64(is_64),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready), .out_valid(out_valid),
        .out_value(out_value), .out_len(out_len), .out_ready(out_ready), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Scoreboard: pop on every result handshake or newly raised error
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ((out_valid && out_ready) || (error && !err_d))) begin
            if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
            else begin
                e = exp_q.pop_front();
                check("err_flag", 64'(error), 64'(e.err));
                if (!e.err) begin
                    check("value", out_value, e.v);
                    check("len", 64'(out_len), 64'(e.len));
                end
            end
        end
        err_d <= error;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input logic err, input logic [63:0] v, input logic [3:0] len);
        exp_t e;
        e.err = err;
        e.v = v;
        e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic start_dec(input logic s, input logic w);
        start = 1'b1;
        is_signed = s;
        is_64 = w;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic chk_lat);
        foreach (bq[i]) begin
            int n = 0;
            in_valid = 1'b1;
            in_byte = bq[i];
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        if (chk_lat) check("latency", 64'(out_valid | error), 64'd1);
    endtask

    task automatic decode(input logic s, input logic w, input logic err, input logic [63:0] v, input logic [3:0] len);
        expect_res(err, v, len);
        start_dec(s, w);
        feed(1'b1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_value", out_value, 64'd0);
        check("rst_len", 64'(out_len), 64'd0);
        reset = 1'b0;
        tick();

        bq = '{8'hE5, 8'h8E, 8'h26};
        decode(1'b0, 1'b0, 1'b0, 64'h0000_0000_0009_8765, 4'd3);
        bq = '{8'hC0, 8'hBB, 8'h78};
        decode(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3);
        bq = '{8'h7F};
        decode(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1);
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        decode(1'b0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd5);

        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
        decode(1'b0, 1'b0, 1'b1, 64'd0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            check("err_held", 64'(error), 64'd1);
            check("err_in_ready", 64'(in_ready), 64'd0);
            check("err_out_valid", 64'(out_valid), 64'd0);
            tick();
        end

        bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        decode(1'b0, 1'b0, 1'b1, 64'd0, 4'd0);
        bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
        decode(1'b1, 1'b1, 1'b1, 64'd0, 4'd0);
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
        decode(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10);
        bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
        decode(1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 4'd10);
        bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h78};
        decode(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0000, 4'd5);

        out_ready = 1'b0;
        expect_res(1'b0, 64'h2A, 4'd1);
        start_dec(1'b0, 1'b0);
        bq = '{8'h2A};
        feed(1'b1);
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_value", out_value, 64'h2A);
            check("bp_len", 64'(out_len), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        expect_res(1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 4'd1);
        start_dec(1'b1, 1'b0);
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        check("b2b_out_valid", 64'(out_valid), 64'd0);
        bq = '{8'h40};
        feed(1'b1);
        tick();

        start_dec(1'b0, 1'b0);
        bq = '{8'hE5, 8'h8E};
        feed(1'b0);
        reset = 1'b1;
        tick();
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_error", 64'(error), 64'd0);
        check("mid_rst_value", out_value, 64'd0);
        check("mid_rst_len", 64'(out_len), 64'd0);
        reset = 1'b0;
        tick();
        bq = '{8'h05};
        decode(1'b0, 1'b0, 1'b0, 64'd5, 4'd1);

        tick();
        tick();
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
